// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
// with valid/ready request and response handshakes and a completed-operation counter.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_inp1,
  output logic [WIDTH-1:0] alu_inp2,
  input  logic [WIDTH-1:0] alu_outp,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNTW-1:0]  cnt_q;
  logic             g0, g1, req_hs, rsp_hs;

  // last_q names the requester served most recently; the other one wins a tie
  always_comb begin
    g0         = req0_valid & (~req1_valid | last_q);
    g1         = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state_q == IDLE) & g0;
    req1_ready = (state_q == IDLE) & g1;
    rsp0_valid = (state_q == RESP) & ~id_q;
    rsp1_valid = (state_q == RESP) & id_q;
    req_hs     = req0_ready | req1_ready;
    rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
    state_d    = state_q;
    if (state_q == IDLE && req_hs) state_d = EXEC;
    if (state_q == EXEC) state_d = RESP;
    if (state_q == RESP && rsp_hs) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        id_q <= req1_ready;
        op_q <= req1_ready ? req1_op : req0_op;
        a_q  <= req1_ready ? req1_a : req0_a;
        b_q  <= req1_ready ? req1_b : req0_b;
      end
      if (state_q == EXEC) res_q <= alu_outp;
      if (rsp_hs) begin
        last_q <= id_q;
        cnt_q  <= cnt_q + CNTW'(1);
      end
    end
  end

  assign alu_op   = op_q;
  assign alu_inp1 = a_q;
  assign alu_inp2 = b_q;
  assign rsp_data = res_q;
  assign busy     = state_q != IDLE;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_inp1, alu_inp2, alu_outp;
  logic        busy;
  logic [3:0]  op_count;

  logic        pv[2], rspr[2];
  logic [2:0]  pop[2];
  logic [31:0] pa[2], pb[2];
  logic        lg;
  int          cnt, npass, ntot;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b;
      3'd3: return a >> b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign alu_outp = alu_f(alu_op, alu_inp1, alu_inp2);

  alu_arbiter #(.WIDTH(32), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_op(alu_op), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_outp(alu_outp),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive();
    req0_valid = pv[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pv[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
    rsp0_ready = rspr[0]; rsp1_ready = rspr[1];
  endtask

  task automatic set_req(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    pv[n] = 1; pop[n] = op; pa[n] = a; pb[n] = b;
  endtask

  task automatic model_reset();
    pv[0] = 0; pv[1] = 0; rspr[0] = 0; rspr[1] = 0; lg = 1; cnt = 0;
  endtask

  // Called at a point in an IDLE cycle; runs one full request/response transaction.
  task automatic serve(input int bp);
    int g;
    logic [31:0] e;
    logic [2:0] op;
    logic [31:0] a, b;
    drive(); #1;
    g = (pv[0] && pv[1]) ? (lg ? 0 : 1) : (pv[0] ? 0 : 1);
    op = pop[g]; a = pa[g]; b = pb[g];
    e = alu_f(op, a, b);
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("busy_idle", busy, 0);
    @(negedge clk); pv[g] = 0; drive(); #1;
    chk("busy_exec", busy, 1);
    chk("rdy_exec", {req0_ready, req1_ready}, 0);
    chk("rspv_exec", {rsp0_valid, rsp1_valid}, 0);
    chk("alu_op", alu_op, op);
    chk("alu_inp1", alu_inp1, a);
    chk("alu_inp2", alu_inp2, b);
    for (int i = 0; i <= bp; i++) begin
      @(negedge clk);
      rspr[g] = (i == bp); rspr[1-g] = 1'($urandom); drive(); #1;
      chk("rsp0_valid", rsp0_valid, g == 0);
      chk("rsp1_valid", rsp1_valid, g == 1);
      chk("rsp_data", rsp_data, e);
      chk("rdy_resp", {req0_ready, req1_ready}, 0);
      chk("busy_resp", busy, 1);
    end
    @(negedge clk); rspr[0] = 0; rspr[1] = 0; drive(); #1;
    lg = g[0]; cnt++;
    chk("op_count", op_count, cnt % 16);
    chk("busy_done", busy, 0);
    chk("rsp_hold", rsp_data, e);
    chk("rspv_done", {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    npass = 0; ntot = 0;
    model_reset(); pop[0] = 0; pa[0] = 0; pb[0] = 0; pop[1] = 0; pa[1] = 0; pb[1] = 0;
    drive();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    @(negedge clk); @(negedge clk); rst = 0;
    // single op
    set_req(0, 3'b000, 5, 7); serve(0);
    chk("t2_data", rsp_data, 12);
    chk("t2_cnt", op_count, 1);
    // asynchronous reset between edges
    #2 rst = 1; #1;
    chk("arst_cnt", op_count, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_alu", {alu_op, alu_inp1}, 0);
    @(negedge clk); rst = 0; model_reset();
    // contention and alternation
    set_req(0, 3'b001, 3, 5); set_req(1, 3'b010, 1, 4);
    serve(1); chk("t3_first", rsp_data, 32'hFFFFFFFE);
    serve(0); chk("t3_second", rsp_data, 16);
    set_req(0, 3'b100, 32'hFF00FF00, 32'h0FF00FF0); set_req(1, 3'b101, 1, 2);
    serve(0); chk("t3_alt", rsp_data, 32'h0F000F00);
    chk("t3_cnt", op_count, 3);
    // backpressure on requester 1 with requester 0 waiting
    set_req(0, 3'b011, 32'h80000000, 32); set_req(1, 3'b110, 32'hF0F0F0F0, 32'hFFFF0000);
    serve(10); chk("t4_xor", rsp_data, 32'h0F0FF0F0);
    serve(0); chk("t5_shr32", rsp_data, 0);
    set_req(0, 3'b111, 32'h0000FFFF, 32'h12345678);
    serve(2); chk("t5_not", rsp_data, 32'hFFFF0000);
    // reset while a response is pending
    set_req(0, 3'b000, 1, 1); drive(); #1;
    @(negedge clk); pv[0] = 0; drive();
    @(negedge clk); #1;
    chk("t6_pre", rsp0_valid, 1);
    #1 rst = 1; #1;
    chk("t6_rspv", rsp0_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", op_count, 0);
    @(negedge clk); rst = 0; model_reset();
    set_req(1, 3'b000, 100, 23); serve(0);
    chk("t6_req1", rsp_data, 123);
    // randomized traffic, wrapping the 4-bit counter several times
    for (int k = 0; k < 60; k++) begin
      for (int n = 0; n < 2; n++)
        if (!pv[n] && ($urandom % 3 != 0))
          set_req(n, 3'($urandom), $urandom, ($urandom % 2) ? $urandom_range(0, 40) : $urandom);
      if (!pv[0] && !pv[1]) set_req(int'($urandom % 2), 3'($urandom), $urandom, $urandom_range(0, 40));
      serve($urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
